// File: rtl/uart_byte_tx.sv
// uart_byte_tx: FIFO-buffered UART transmitter, one 8N1/8N2 frame per queued byte, LSB first
// clk   : divided block clock, rising edge
// rst   : synchronous active-low reset
// data  : byte to queue, taken when valid && ready
// valid : upstream has a byte on data
// ready : FIFO not full
// out   : serial line, idles high, registered
// busy  : frame in progress or bytes queued
// level : FIFO occupancy
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int LI = CLKS_PER_BIT - 1;
  localparam int SL = STOP_BITS - 1;
  localparam logic [AW:0]   FULL  = FIFO_DEPTH[AW:0];
  localparam logic [CW-1:0] LAST  = LI[CW-1:0];
  localparam logic [2:0]    SLAST = SL[2:0];
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_byte_tx: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_byte_tx: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_byte_tx: FIFO_DEPTH must be a power of 2, at least 2");
  end
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          out_q, out_d;
  logic          push, pop, tick;
  assign ready = level_q != FULL;
  assign out   = out_q;
  assign busy  = state_q != IDLE || level_q != '0;
  assign level = level_q;
  // bit_q doubles as the stop-bit index while in STOP so the baud counter
  // only ever spans one bit time
  always_comb begin
    push    = valid && ready;
    tick    = cnt_q == LAST;
    pop     = 1'b0;
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        shift_d = {1'b0, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: if (tick) begin
        if (bit_q != SLAST) bit_d = bit_q + 3'd1;
        else if (level_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (pop) shift_d = mem_q[rd_q];
    // line level follows the current state, so out trails state by one edge
    out_d   = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    level_d = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      out_q   <= out_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= data;
  end
endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: directed checks of uart_byte_tx framing, latency, backpressure and reset
module tb_uart_byte_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, ready_b, out_a, out_b, busy_a, busy_b;
  logic [2:0] level_a, level_b;
  int         total = 0;
  int         bad = 0;
  logic [63:0] cap [8];
  always #5 clk = ~clk;
  uart_byte_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .data(data_a), .valid(valid_a), .ready(ready_a),
    .out(out_a), .busy(busy_a), .level(level_a));
  uart_byte_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .data(data_b), .valid(valid_b), .ready(ready_b),
    .out(out_b), .busy(busy_b), .level(level_b));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] frame(input logic [7:0] b, input int cpb, input int sb);
    logic [63:0] v;
    int s;
    v = '0;
    for (int j = 0; j < (9 + sb) * cpb; j++) begin
      s = j / cpb;
      v[j] = s == 0 ? 1'b0 : s <= 8 ? b[s-1] : 1'b1;
    end
    return v;
  endfunction
  task automatic find_start(input bit w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((w ? out_b : out_a) == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic grab(input bit w, input int n, input int s, output logic [63:0] v);
    v = '0;
    for (int i = s; i < n; i++) begin
      @(negedge clk);
      v[i] = w ? out_b : out_a;
    end
  endtask
  task automatic rx(input bit w, input int k, input int n);
    bit ok;
    find_start(w, ok);
    chk("rx_start", 64'(ok), 64'd1);
    for (int f = 0; f < k; f++) grab(w, n, f == 0 ? 1 : 0, cap[f]);
  endtask
  task automatic push_a(input logic [7:0] b);
    data_a = b;
    valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [63:0] v;
    logic [7:0] p3 [7] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    logic [7:0] p6 [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hA5};
    int n;
    repeat (3) @(negedge clk);
    chk("rst_out", 64'(out_a), 64'd1);
    chk("rst_ready", 64'(ready_a), 64'd1);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_level", 64'(level_a), 64'd0);
    chk("rst_out_b", 64'(out_b), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    // single byte 'L': latency, exact waveform, busy drop
    push_a(8'h4C);
    chk("lat_t0_out", 64'(out_a), 64'd1);
    @(negedge clk);
    chk("lat_t1_out", 64'(out_a), 64'd1);
    chk("lat_t1_level", 64'(level_a), 64'd0);
    chk("lat_t1_busy", 64'(busy_a), 64'd1);
    grab(1'b0, 40, 0, v);
    chk("frame_L", v, 64'hF0F00FF000);
    @(negedge clk);
    chk("L_busy_end", 64'(busy_a), 64'd0);
    repeat (8) @(negedge clk);
    chk("L_idle_out", 64'(out_a), 64'd1);
    chk("L_idle_busy", 64'(busy_a), 64'd0);
    // back-to-back 'N','1','3'
    data_a = 8'h4E;
    valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_a = 8'h31;
    @(posedge clk);
    @(negedge clk);
    data_a = 8'h33;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    chk("b2b_level_peak", 64'(level_a), 64'd2);
    rx(1'b0, 3, 40);
    chk("b2b_f0", cap[0], frame(8'h4E, 4, 1));
    chk("b2b_f1", cap[1], frame(8'h31, 4, 1));
    chk("b2b_f2", cap[2], frame(8'h33, 4, 1));
    @(negedge clk);
    chk("b2b_busy_end", 64'(busy_a), 64'd0);
    // backpressure with 7 bytes and valid held
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          data_a = p3[k];
          valid_a = 1'b1;
          @(posedge clk);
          @(negedge clk);
        end
        chk("bp_ready_low", 64'(ready_a), 64'd0);
        chk("bp_level_full", 64'(level_a), 64'd4);
        data_a = p3[5];
        n = 0;
        while (!ready_a && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("bp_wait1", 64'(n), 64'd37);
        @(posedge clk);
        @(negedge clk);
        chk("bp_refill", 64'(level_a), 64'd4);
        data_a = p3[6];
        n = 0;
        while (!ready_a && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("bp_wait2", 64'(n), 64'd39);
        @(posedge clk);
        @(negedge clk);
        valid_a = 1'b0;
      end
      rx(1'b0, 7, 40);
    join
    for (int f = 0; f < 7; f++) chk($sformatf("bp_f%0d", f), cap[f], frame(p3[f], 4, 1));
    @(negedge clk);
    chk("bp_busy_end", 64'(busy_a), 64'd0);
    // push into last free slot on the same edge as the end-of-stop pop
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          data_a = p6[k];
          valid_a = 1'b1;
          @(posedge clk);
          @(negedge clk);
        end
        valid_a = 1'b0;
        chk("pp_fill", 64'(level_a), 64'd3);
        repeat (37) @(negedge clk);
        chk("pp_pre", 64'(level_a), 64'd3);
        data_a = p6[4];
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        chk("pp_level", 64'(level_a), 64'd3);
        chk("pp_ready", 64'(ready_a), 64'd1);
      end
      rx(1'b0, 5, 40);
    join
    for (int f = 0; f < 5; f++) chk($sformatf("pp_f%0d", f), cap[f], frame(p6[f], 4, 1));
    // two stop bits, CLKS_PER_BIT=3: 0xFF then 0x00
    data_b = 8'hFF;
    valid_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_b = 8'h00;
    @(posedge clk);
    @(negedge clk);
    valid_b = 1'b0;
    chk("s2_level", 64'(level_b), 64'd1);
    chk("s2_busy", 64'(busy_b), 64'd1);
    rx(1'b1, 2, 33);
    chk("s2_frame_ff", cap[0], 64'h1FFFFFFF8);
    chk("s2_frame_00", cap[1], 64'h1F8000000);
    @(negedge clk);
    chk("s2_busy_end", 64'(busy_b), 64'd0);
    // reset during DATA bit 3 with bytes queued
    push_a(8'h11);
    data_a = 8'h22;
    valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_a = 8'h33;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    repeat (15) @(negedge clk);
    chk("mr_pre_busy", 64'(busy_a), 64'd1);
    chk("mr_pre_level", 64'(level_a), 64'd2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mr_out", 64'(out_a), 64'd1);
    chk("mr_level", 64'(level_a), 64'd0);
    chk("mr_busy", 64'(busy_a), 64'd0);
    chk("mr_ready", 64'(ready_a), 64'd1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (!out_a) n++;
    end
    chk("mr_quiet", 64'(n), 64'd0);
    push_a(8'h5A);
    rx(1'b0, 1, 40);
    chk("mr_new_frame", cap[0], frame(8'h5A, 4, 1));
    @(negedge clk);
    chk("mr_busy_end", 64'(busy_a), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
